// File: rtl/compute_clock_gate_ctrl_if.sv
// Command handshake into the compute clock gate controller:
// run mode, step count and channel mask under valid/ready.
interface compute_clock_gate_ctrl_if #(
    parameter int NUM_CHANNELS = 4,
    parameter int COUNT_WIDTH  = 32
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [1:0]              cmd_mode;
    logic [COUNT_WIDTH-1:0]  cmd_count;
    logic [NUM_CHANNELS-1:0] cmd_mask;

    modport master (
        output cmd_valid, cmd_mode, cmd_count, cmd_mask,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_count, cmd_mask,
        output cmd_ready
    );
endinterface

// File: rtl/compute_clock_gate_ctrl.sv
// Lock filtering, reset-release sequencing and per-channel
// compute clock enable generation for the clock wizard.
module compute_clock_gate_ctrl #(
    parameter int NUM_CHANNELS = 4,
    parameter int SYNC_STAGES  = 3,
    parameter int LOCK_FILTER  = 8,
    parameter int COUNT_WIDTH  = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    locked,
    output logic                    sync_rst_n,
    compute_clock_gate_ctrl_if.slave cmd,
    output logic [NUM_CHANNELS-1:0] clock_en,
    output logic                    busy,
    output logic                    done,
    output logic                    cmd_error,
    output logic [COUNT_WIDTH-1:0]  cycles_run
);
    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam logic [1:0] MODE_FREE  = 2'b01;
    localparam logic [1:0] MODE_COUNT = 2'b10;

    typedef enum logic [1:0] {
        HOLD,
        IDLE,
        RUN_FREE,
        RUN_COUNT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] lk_sync;
    logic [SYNC_STAGES-1:0] rel_chain;
    logic [FW-1:0]          filt;
    logic [COUNT_WIDTH-1:0] left;
    logic [COUNT_WIDTH-1:0] cycles_inc;
    logic                   lk_s;
    logic                   rel;
    logic                   ready;
    logic                   accept;
    logic                   run_cmd;

    assign lk_s       = lk_sync[SYNC_STAGES-1];
    // A low lk_s drops release in the same cycle, ahead of the counter clear.
    assign rel        = lk_s && (filt == FW'(LOCK_FILTER));
    assign sync_rst_n = rel_chain[SYNC_STAGES-1];
    assign ready      = sync_rst_n && (state != HOLD);
    assign cmd.cmd_ready = ready;
    assign accept     = cmd.cmd_valid && ready;
    assign run_cmd    = (cmd.cmd_mode == MODE_FREE) ||
                        (cmd.cmd_mode == MODE_COUNT);
    assign cycles_inc = (&cycles_run) ? cycles_run
                                      : cycles_run + COUNT_WIDTH'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lk_sync   <= '0;
            filt      <= '0;
            rel_chain <= '0;
        end else begin
            lk_sync <= {lk_sync[SYNC_STAGES-2:0], locked};
            if (!lk_s) begin
                filt <= '0;
            end else if (filt != FW'(LOCK_FILTER)) begin
                filt <= filt + FW'(1);
            end
            rel_chain <= rel ? {rel_chain[SYNC_STAGES-2:0], 1'b1} : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= HOLD;
            clock_en   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cmd_error  <= 1'b0;
            cycles_run <= '0;
            left       <= '0;
        end else begin
            done      <= 1'b0;
            cmd_error <= 1'b0;
            if (!sync_rst_n) begin
                state    <= HOLD;
                clock_en <= '0;
                busy     <= 1'b0;
            end else begin
                unique case (state)
                    HOLD: state <= IDLE;
                    IDLE: begin
                        if (accept && cmd.cmd_mode == MODE_FREE) begin
                            state      <= RUN_FREE;
                            clock_en   <= cmd.cmd_mask;
                            busy       <= 1'b1;
                            cycles_run <= '0;
                        end else if (accept && cmd.cmd_mode == MODE_COUNT) begin
                            cycles_run <= '0;
                            if (cmd.cmd_count == '0) begin
                                done <= 1'b1;
                            end else begin
                                state    <= RUN_COUNT;
                                clock_en <= cmd.cmd_mask;
                                busy     <= 1'b1;
                                left     <= cmd.cmd_count;
                            end
                        end
                    end
                    RUN_FREE, RUN_COUNT: begin
                        cycles_run <= cycles_inc;
                        left       <= left - COUNT_WIDTH'(1);
                        if (accept && run_cmd) begin
                            cmd_error <= 1'b1;
                        end
                        if ((accept && !run_cmd) ||
                            (state == RUN_COUNT && left == COUNT_WIDTH'(1))) begin
                            state    <= IDLE;
                            clock_en <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end
                    end
                    default: state <= HOLD;
                endcase
            end
        end
    end
endmodule
